// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
//
// Shared definitions for the sign-magnitude divider family.
//
// The divider and its companion dividend_reconstructor both exchange operands
// as a separate sign bit plus an unsigned magnitude. This package holds:
//   MAG_W / RES_W / SUM_W / CNT_W - operand, result, internal-sum and
//                                    bit-counter widths
//   sm_operand_t                  - {sign, mag} operand at MAG_W
//   sm_result_t                   - {sign, mag} result at RES_W
//   sm_to_signed()                - sign-magnitude -> SUM_W two's complement
//   to_sign_mag()                 - SUM_W two's complement -> sign-magnitude,
//                                    normalising zero to a positive sign
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int MAG_W = 3;
    localparam int RES_W = 2 * MAG_W;
    // Two guard bits: one for the sign, one so |prod| + |rem| cannot wrap.
    localparam int SUM_W = RES_W + 2;
    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_operand_t;

    typedef struct packed {
        logic             sign;
        logic [RES_W-1:0] mag;
    } sm_result_t;

    // Widen a sign-magnitude value into SUM_W-bit two's complement.
    function automatic logic [SUM_W-1:0] sm_to_signed(input logic sign,
                                                      input logic [RES_W-1:0] mag);
        logic [SUM_W-1:0] ext;
        ext = SUM_W'(mag);
        return sign ? (~ext + SUM_W'(1)) : ext;
    endfunction

    // Back to sign-magnitude. A zero magnitude always comes out positive so
    // the divider family never produces a "negative zero".
    function automatic sm_result_t to_sign_mag(input logic [SUM_W-1:0] value);
        sm_result_t r;
        logic       neg;
        neg    = value[SUM_W-1];
        r.mag  = RES_W'(neg ? (~value + SUM_W'(1)) : value);
        r.sign = neg && (r.mag != '0);
        return r;
    endfunction

endpackage

// File: rtl/sm_shift_add_mul.sv
// ---------------------------------------------------------------------------
// sm_shift_add_mul
//
// Unsigned sequential shift-add multiplier, one multiplier bit per clock,
// LSB first. Takes MAG_W cycles after start.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - load operands, clear accumulator and counter
//   multiplicand  - MAG_W-bit value that is shifted and added
//   multiplier    - MAG_W-bit value whose bits select the partial products
//   done          - high during the cycle whose closing edge adds the last
//                   partial product; product is final after that edge
//   product       - RES_W-bit accumulator
// ---------------------------------------------------------------------------
module sm_shift_add_mul
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAG_W-1:0] multiplicand,
    input  logic [MAG_W-1:0] multiplier,
    output logic             done,
    output logic [RES_W-1:0] product
);

    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0] mcand_q, mcand_d;
    logic [MAG_W-1:0] mplier_q, mplier_d;
    logic [RES_W-1:0] acc_q, acc_d;

    logic             last_bit;

    // The final bit is reported combinationally so the owner can change
    // state on the same edge that adds the last partial product, which keeps
    // the multiply phase exactly MAG_W cycles long.
    assign last_bit = running_q && (cnt_q == CNT_W'(MAG_W - 1));
    assign done     = last_bit;
    assign product  = acc_q;

    // Next-state logic: a start reloads everything; otherwise each running
    // cycle adds the shifted multiplicand when the current multiplier bit is
    // set, then advances the bit counter.
    always_comb begin
        running_d = running_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;

        if (start) begin
            running_d = 1'b1;
            cnt_d     = '0;
            mcand_d   = multiplicand;
            mplier_d  = multiplier;
            acc_d     = '0;
        end else if (running_q) begin
            if (mplier_q[cnt_q]) begin
                acc_d = acc_q + (RES_W'(mcand_q) << cnt_q);
            end
            if (last_bit) begin
                running_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
        end else begin
            running_q <= running_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: rtl/dividend_reconstructor.sv
// ---------------------------------------------------------------------------
// dividend_reconstructor
//
// Checker/decoder that sits next to the sign-magnitude divider. Given the
// divider's quotient, divisor and remainder it rebuilds dividend = q*d + r
// and flags triples that the divider could not have produced.
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   start                         - one-cycle request, only honoured in IDLE
//   quo_mag/quo_sign              - quotient
//   div_mag/div_sign              - divisor
//   rem_mag/rem_sign              - remainder
//   busy                          - operation in progress
//   valid                         - one-cycle pulse when results update
//   res_mag/res_sign              - reconstructed dividend (never -0)
//   err                           - triple is inconsistent or overflow-coded
//
// Flow: IDLE --start--> MUL (MAG_W cycles) --> ADD (1 cycle) --> IDLE.
// ---------------------------------------------------------------------------
module dividend_reconstructor
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAG_W-1:0] quo_mag,
    input  logic             quo_sign,
    input  logic [MAG_W-1:0] div_mag,
    input  logic             div_sign,
    input  logic [MAG_W-1:0] rem_mag,
    input  logic             rem_sign,
    output logic             busy,
    output logic             valid,
    output logic [RES_W-1:0] res_mag,
    output logic             res_sign,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_ADD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             quo_sign_q, quo_sign_d;
    sm_operand_t      div_q, div_d;
    sm_operand_t      rem_q, rem_d;
    sm_result_t       res_q, res_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic             mul_start;
    logic             mul_done;
    logic [RES_W-1:0] product;

    logic             prod_sign;
    logic [SUM_W-1:0] sum;
    sm_result_t       sum_sm;
    logic             err_calc;

    // The multiplier latches quo_mag and div_mag itself on mul_start, so the
    // quotient magnitude is not kept a second time here.
    sm_shift_add_mul u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (div_mag),
        .multiplier   (quo_mag),
        .done         (mul_done),
        .product      (product)
    );

    // Final signed add and consistency checks. These only matter in ADD,
    // where the latched operands and the finished product are stable.
    // The product-nonzero test (rather than quotient-nonzero) means a zero
    // divisor does not also trip the sign rule; it is flagged on its own.
    always_comb begin
        prod_sign = quo_sign_q ^ div_q.sign;
        sum       = sm_to_signed(prod_sign, product)
                  + sm_to_signed(rem_q.sign, RES_W'(rem_q.mag));
        sum_sm    = to_sign_mag(sum);
        err_calc  = (div_q.mag == '0)
                 || (rem_q.mag >= div_q.mag)
                 || ((rem_q.mag != '0) && (product != '0) && (rem_q.sign != prod_sign))
                 || ((rem_q.mag == '0) && rem_q.sign);
    end

    // Control FSM. Result registers hold between operations; valid is a
    // single-cycle pulse raised only by the ADD state.
    always_comb begin
        state_d    = state_q;
        quo_sign_d = quo_sign_q;
        div_d      = div_q;
        rem_d      = rem_q;
        res_d      = res_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        mul_start  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    quo_sign_d = quo_sign;
                    div_d      = '{sign: div_sign, mag: div_mag};
                    rem_d      = '{sign: rem_sign, mag: rem_mag};
                    mul_start  = 1'b1;
                    state_d    = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                res_d   = sum_sm;
                err_d   = err_calc;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            quo_sign_q <= 1'b0;
            div_q      <= '0;
            rem_q      <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            quo_sign_q <= quo_sign_d;
            div_q      <= div_d;
            rem_q      <= rem_d;
            res_q      <= res_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign valid    = valid_q;
    assign res_mag  = res_q.mag;
    assign res_sign = res_q.sign;
    assign err      = err_q;

endmodule

// File: tb/tb_dividend_reconstructor.sv
// ---------------------------------------------------------------------------
// tb_dividend_reconstructor
//
// Directed stimulus with hand-computed expected dividends. Each issued
// operation pushes its expected result onto a queue; an independent monitor
// pops and compares whenever the DUT pulses valid.
// ---------------------------------------------------------------------------
module tb_dividend_reconstructor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] quo_mag, div_mag, rem_mag;
    logic       quo_sign, div_sign, rem_sign;
    logic       busy, valid;
    logic [5:0] res_mag;
    logic       res_sign;
    logic       err;

    typedef struct {
        logic [5:0] mag;
        logic       sign;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dividend_reconstructor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .quo_mag  (quo_mag),
        .quo_sign (quo_sign),
        .div_mag  (div_mag),
        .div_sign (div_sign),
        .rem_mag  (rem_mag),
        .rem_sign (rem_sign),
        .busy     (busy),
        .valid    (valid),
        .res_mag  (res_mag),
        .res_sign (res_sign),
        .err      (err)
    );

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid: got valid with empty queue, expected none");
            end else begin
                e = sb_q.pop_front();
                checkOutput("res_mag",  int'(res_mag),  int'(e.mag));
                checkOutput("res_sign", int'(res_sign), int'(e.sign));
                checkOutput("err",      int'(err),      int'(e.err));
            end
        end
    end

    task automatic driveOperands(input logic [2:0] qm, input logic qs,
                                 input logic [2:0] dm, input logic ds,
                                 input logic [2:0] rm, input logic rs);
        quo_mag  = qm; quo_sign = qs;
        div_mag  = dm; div_sign = ds;
        rem_mag  = rm; rem_sign = rs;
    endtask

    // Issue one operation, queue its expectation and wait (bounded) for valid.
    task automatic applyStimulus(input logic [2:0] qm, input logic qs,
                                 input logic [2:0] dm, input logic ds,
                                 input logic [2:0] rm, input logic rs,
                                 input logic [5:0] em, input logic es, input logic ee);
        exp_t e;
        int   busy_cycles;
        int   waited;
        @(negedge clk);
        driveOperands(qm, qs, dm, ds, rm, rs);
        start = 1'b1;
        e.mag = em; e.sign = es; e.err = ee;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        driveOperands(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        busy_cycles = 0;
        waited      = 0;
        while (valid !== 1'b1 && waited < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL valid_timeout: got no valid in %0d cycles, expected 4", waited);
        end else begin
            checkOutput("busy_cycles", busy_cycles, 4);
            checkOutput("busy_at_valid", int'(busy), 0);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int vcount;
        rst_n = 1'b0;
        start = 1'b0;
        driveOperands(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        #12;
        $display("[TB] checking reset state");
        checkOutput("reset_busy",     int'(busy),     0);
        checkOutput("reset_valid",    int'(valid),    0);
        checkOutput("reset_res_mag",  int'(res_mag),  0);
        checkOutput("reset_res_sign", int'(res_sign), 0);
        checkOutput("reset_err",      int'(err),      0);
        @(negedge clk);
        rst_n = 1'b1;

        // q, d, r (mag, sign) -> expected res_mag, res_sign, err
        applyStimulus(3'd3, 0, 3'd2, 0, 3'd1, 0, 6'd7,  0, 0);  //  3*2+1   =  7
        repeat (3) @(negedge clk);
        checkOutput("hold_res_mag", int'(res_mag), 7);
        checkOutput("hold_valid",   int'(valid),   0);
        applyStimulus(3'd2, 1, 3'd3, 0, 3'd1, 1, 6'd7,  1, 0);  // -2*3-1   = -7
        applyStimulus(3'd7, 1, 3'd7, 1, 3'd7, 1, 6'd42, 0, 1);  //  49-7    = 42, overflow code
        applyStimulus(3'd1, 0, 3'd3, 0, 3'd5, 0, 6'd8,  0, 1);  //  3+5, r>=d
        applyStimulus(3'd2, 0, 3'd3, 0, 3'd1, 1, 6'd5,  0, 1);  //  6-1, sign mismatch
        applyStimulus(3'd0, 0, 3'd5, 0, 3'd0, 1, 6'd0,  0, 1);  //  negative zero remainder
        applyStimulus(3'd0, 0, 3'd5, 0, 3'd0, 0, 6'd0,  0, 0);  //  clean zero
        applyStimulus(3'd7, 0, 3'd7, 1, 3'd6, 1, 6'd55, 1, 0);  // -49-6    = -55
        applyStimulus(3'd2, 1, 3'd3, 1, 3'd2, 0, 6'd8,  0, 0);  //  6+2     =  8
        applyStimulus(3'd1, 0, 3'd0, 0, 3'd0, 0, 6'd0,  0, 1);  //  zero divisor
        applyStimulus(3'd1, 1, 3'd2, 0, 3'd2, 0, 6'd0,  0, 1);  // -2+2 = 0, forced positive

        // Second start during MUL, with operand inputs changed, is ignored.
        $display("[TB] start while busy");
        @(negedge clk);
        driveOperands(3'd3, 0, 3'd4, 0, 3'd2, 0);                // 12+2 = 14
        start = 1'b1;
        sb_q.push_back('{6'd14, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        driveOperands(3'd7, 1, 3'd1, 0, 3'd0, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        checkOutput("single_valid", vcount, 1);

        // Reset two cycles into an operation aborts it without a valid.
        $display("[TB] reset mid-operation");
        @(negedge clk);
        driveOperands(3'd5, 0, 3'd5, 0, 3'd1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_res_mag",  int'(res_mag),  0);
        checkOutput("abort_res_sign", int'(res_sign), 0);
        checkOutput("abort_err",      int'(err),      0);
        checkOutput("abort_busy",     int'(busy),     0);
        checkOutput("abort_valid",    int'(valid),    0);
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        checkOutput("abort_no_valid", vcount, 0);
        applyStimulus(3'd5, 0, 3'd5, 0, 3'd1, 0, 6'd26, 0, 0);  // 25+1 = 26

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
